// File: rtl/mac_acc_16_if.sv
// Handshake bundle for mac_acc_16: product input side and block result side.
// Ports: prod_in/prod_valid/prod_ready in; acc_out/acc_valid/acc_ready/acc_sat/beat_cnt out.
interface mac_acc_16_if #(
    parameter int ACC_W = 24
);
    logic [15:0]      prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             acc_sat;
    logic [7:0]       beat_cnt;

    modport master (
        output prod_in, prod_valid, acc_ready,
        input  prod_ready, acc_out, acc_valid, acc_sat, beat_cnt
    );

    modport slave (
        input  prod_in, prod_valid, acc_ready,
        output prod_ready, acc_out, acc_valid, acc_sat, beat_cnt
    );
endinterface

// File: rtl/mac_acc_16.sv
// Block accumulator for signed 16-bit products, LEN beats per block, sat or wrap.
// Ports: sys_clk, sys_rst_n (async low), clr (sync abort), bus (slave handshake bundle).
module mac_acc_16 #(
    parameter int ACC_W  = 24,
    parameter int LEN    = 8,
    parameter int SAT_EN = 1
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         clr,
    mac_acc_16_if.slave  bus
);
    typedef enum logic {S_ACC, S_OUT} state_t;

    localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]       LAST  = 8'(LEN - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             sat_r;
    logic [7:0]       cnt;
    logic [ACC_W-1:0] out_r;
    logic             valid_r;
    logic             osat_r;

    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] nxt;

    // One guard bit catches overflow of a single beat.
    always_comb begin
        sum = {acc[ACC_W-1], acc}
            + {{(ACC_W-15){bus.prod_in[15]}}, bus.prod_in};
        ovf = sum[ACC_W] ^ sum[ACC_W-1];
        nxt = sum[ACC_W-1:0];
        if (ovf && SAT_EN != 0) begin
            nxt = sum[ACC_W] ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_ACC;
            acc     <= '0;
            sat_r   <= 1'b0;
            cnt     <= '0;
            out_r   <= '0;
            valid_r <= 1'b0;
            osat_r  <= 1'b0;
        end else if (clr) begin
            state   <= S_ACC;
            acc     <= '0;
            sat_r   <= 1'b0;
            cnt     <= '0;
            valid_r <= 1'b0;
        end else begin
            unique case (state)
                S_ACC: begin
                    if (bus.prod_valid) begin
                        if (cnt == LAST) begin
                            out_r   <= nxt;
                            osat_r  <= sat_r | ovf;
                            valid_r <= 1'b1;
                            acc     <= '0;
                            sat_r   <= 1'b0;
                            cnt     <= '0;
                            state   <= S_OUT;
                        end else begin
                            acc   <= nxt;
                            sat_r <= sat_r | ovf;
                            cnt   <= cnt + 8'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.acc_ready) begin
                        valid_r <= 1'b0;
                        state   <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

    assign bus.prod_ready = (state == S_ACC);
    assign bus.acc_out    = out_r;
    assign bus.acc_valid  = valid_r;
    assign bus.acc_sat    = osat_r;
    assign bus.beat_cnt   = cnt;
endmodule
